// File: rtl/gb_bus_pkg.sv
// ============================================================================
// Module      : gb_bus_pkg
// Description : Shared event field widths, kind codes and strobe FSM types
//               for the GameBoy bus logger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gb_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int DROP_W = 8;
    localparam int EVT_W  = 1 + ADDR_W + DATA_W;

    localparam logic KIND_WR = 1'b0;
    localparam logic KIND_RD = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOW  = 1'b1
    } strobe_state_t;

    function automatic logic [DROP_W-1:0] sat_add_drops(
        input logic [DROP_W-1:0] cur,
        input logic [1:0]        inc
    );
        logic [DROP_W:0] sum;
        sum = {1'b0, cur} + {{(DROP_W-1){1'b0}}, inc};
        return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/gb_evt_fifo.sv
// ============================================================================
// Module      : gb_evt_fifo
// Description : Single-clock first-word-fall-through event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gb_evt_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
)
(
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LEVEL);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && n_reset && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (!do_push && do_pop) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gb_strobe_fsm.sv
// ============================================================================
// Module      : gb_strobe_fsm
// Description : Qualifies one active-low bus strobe and captures the access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gb_strobe_fsm
    import gb_bus_pkg::*;
#(
    parameter int MIN_LOW = 2
)
(
    input  logic              clk,
    input  logic              n_reset,
    input  logic              clear,
    input  logic              enable,
    input  logic              strobe,
    input  logic              ncs,
    input  logic [ADDR_W-2:0] adr,
    input  logic [DATA_W-1:0] data_in,
    output logic              ev_valid,
    output logic [ADDR_W-1:0] ev_addr,
    output logic [DATA_W-1:0] ev_data
);

    strobe_state_t    state;
    logic [CNT_W-1:0] count;
    logic             strobe_q;

    // strobe_q clears on reset/flush so only a freshly observed falling edge opens an access
    always_ff @(posedge clk) begin
        if (!n_reset || clear) begin
            state    <= ST_IDLE;
            count    <= '0;
            strobe_q <= 1'b0;
            ev_addr  <= '0;
            ev_data  <= '0;
        end else begin
            strobe_q <= strobe;
            case (state)
                ST_IDLE: begin
                    if (enable && strobe_q && !strobe && !ncs) begin
                        state   <= ST_LOW;
                        count   <= CNT_W'(1);
                        ev_addr <= {ncs, adr};
                        ev_data <= data_in;
                    end
                end
                ST_LOW: begin
                    if (!enable || strobe) begin
                        state <= ST_IDLE;
                    end else begin
                        if (count != '1) begin
                            count <= count + CNT_W'(1);
                        end
                        ev_addr <= {ncs, adr};
                        ev_data <= data_in;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ev_valid = (state == ST_LOW) && enable && strobe && (count >= CNT_W'(MIN_LOW));

endmodule

`default_nettype wire

// File: rtl/gb_bus_logger.sv
// ============================================================================
// Module      : gb_bus_logger
// Description : Timestamps GameBoy bus writes (and optionally reads) into a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gb_bus_logger
    import gb_bus_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 25,
    parameter int MIN_LOW  = 2
)
(
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic [14:0]             adr,
    input  logic [7:0]              data_in,
    input  logic                    nrd,
    input  logic                    nwr,
    input  logic                    ncs,
    input  logic                    tick,
    input  logic                    cap_reads,
    input  logic                    clear,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             out_addr,
    output logic [7:0]              out_data,
    output logic                    out_kind,
    output logic [TS_WIDTH-1:0]     out_time,
    output logic [$clog2(DEPTH):0]  level,
    output logic [7:0]              drops
);

    localparam int FW = EVT_W + TS_WIDTH;

    logic [TS_WIDTH-1:0] timestamp;
    logic                wr_ev;
    logic                rd_ev;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   rd_data;
    logic                push;
    logic                pop_eff;
    logic                full;
    logic                empty;
    logic [FW-1:0]       push_data;
    logic [FW-1:0]       head;
    logic [1:0]          lost;

    always_ff @(posedge clk) begin
        if (!n_reset || clear) begin
            timestamp <= '0;
        end else if (tick) begin
            timestamp <= timestamp + 1'b1;
        end
    end

    gb_strobe_fsm #(.MIN_LOW(MIN_LOW)) u_wr_fsm (
        .clk      (clk),
        .n_reset  (n_reset),
        .clear    (clear),
        .enable   (1'b1),
        .strobe   (nwr),
        .ncs      (ncs),
        .adr      (adr),
        .data_in  (data_in),
        .ev_valid (wr_ev),
        .ev_addr  (wr_addr),
        .ev_data  (wr_data)
    );

    gb_strobe_fsm #(.MIN_LOW(MIN_LOW)) u_rd_fsm (
        .clk      (clk),
        .n_reset  (n_reset),
        .clear    (clear),
        .enable   (cap_reads),
        .strobe   (nrd),
        .ncs      (ncs),
        .adr      (adr),
        .data_in  (data_in),
        .ev_valid (rd_ev),
        .ev_addr  (rd_addr),
        .ev_data  (rd_data)
    );

    // The FIFO takes one entry per cycle, so a coincident read loses to the write
    assign push      = wr_ev | rd_ev;
    assign push_data = wr_ev ? {KIND_WR, wr_addr, wr_data, timestamp}
                             : {KIND_RD, rd_addr, rd_data, timestamp};
    assign pop_eff   = out_ready & ~empty;
    assign lost      = {1'b0, wr_ev & rd_ev} + {1'b0, push & full & ~pop_eff};

    gb_evt_fifo #(.DEPTH(DEPTH), .WIDTH(FW)) u_fifo (
        .clk       (clk),
        .n_reset   (n_reset),
        .clear     (clear),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign out_valid = ~empty;
    assign {out_kind, out_addr, out_data, out_time} = head;

    always_ff @(posedge clk) begin
        if (!n_reset || clear) begin
            drops <= '0;
        end else begin
            drops <= sat_add_drops(drops, lost);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gb_bus_logger.sv
// ============================================================================
// Module      : tb_gb_bus_logger
// Description : Directed and randomized bench for gb_bus_logger against a
//               history-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gb_bus_logger;

    localparam int DEPTH   = 16;
    localparam int TSW     = 8;
    localparam int MIN_LOW = 2;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int EW      = 25 + TSW;
    localparam int MAXC    = 8192;

    logic            clk = 1'b0;
    logic            n_reset, nrd, nwr, ncs, tick, cap_reads, clear, out_ready;
    logic [14:0]     adr;
    logic [7:0]      data_in;
    logic            out_valid, out_kind;
    logic [15:0]     out_addr;
    logic [7:0]      out_data;
    logic [TSW-1:0]  out_time;
    logic [LW-1:0]   level;
    logic [7:0]      drops;

    gb_bus_logger #(.DEPTH(DEPTH), .TS_WIDTH(TSW), .MIN_LOW(MIN_LOW)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .adr       (adr),
        .data_in   (data_in),
        .nrd       (nrd),
        .nwr       (nwr),
        .ncs       (ncs),
        .tick      (tick),
        .cap_reads (cap_reads),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_kind  (out_kind),
        .out_time  (out_time),
        .level     (level),
        .drops     (drops)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-edge input history; events are found by looking back over a strobe's low run
    bit          h_blk [MAXC];
    bit          h_nwr [MAXC];
    bit          h_nrd [MAXC];
    bit          h_cap [MAXC];
    bit          h_ncs [MAXC];
    logic [14:0] h_adr [MAXC];
    logic [7:0]  h_dat [MAXC];
    int          n    = 0;
    bit          live = 1'b0;

    logic [EW-1:0] q[$];
    int            m_drops = 0;
    int            m_ts    = 0;

    function automatic bit strb(input bit rd, input int e);
        return rd ? h_nrd[e] : h_nwr[e];
    endfunction

    function automatic bit en(input bit rd, input int e);
        return rd ? h_cap[e] : 1'b1;
    endfunction

    function automatic bit detect(input bit rd, input int e, output logic [15:0] a, output logic [7:0] d);
        int s;
        a = '0;
        d = '0;
        if (!strb(rd, e) || !en(rd, e) || h_blk[e]) return 1'b0;
        s = e;
        while (s > 0 && !strb(rd, s - 1)) begin
            if (h_blk[s-1] || !en(rd, s - 1)) return 1'b0;
            s--;
        end
        if (s == 0 || s == e || h_blk[s-1] || h_ncs[s]) return 1'b0;
        if (e - s < MIN_LOW) return 1'b0;
        a = {h_ncs[e-1], h_adr[e-1]};
        d = h_dat[e-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model_proc
        logic [15:0]   wa, ra;
        logic [7:0]    wd, rdd;
        logic [EW-1:0] item;
        bit            wv, rv, popped;
        int            lost;
        if (n >= MAXC) begin
            $display("FAIL history: cycle budget %0d exhausted", MAXC);
            $fatal(1);
        end
        h_blk[n] = !n_reset || clear;
        h_nwr[n] = nwr;
        h_nrd[n] = nrd;
        h_cap[n] = cap_reads;
        h_ncs[n] = ncs;
        h_adr[n] = adr;
        h_dat[n] = data_in;
        if (h_blk[n]) begin
            q.delete();
            m_drops = 0;
            m_ts    = 0;
        end else begin
            popped = out_ready && q.size() > 0;
            wv     = detect(1'b0, n, wa, wd);
            rv     = detect(1'b1, n, ra, rdd);
            lost   = 0;
            if (popped) void'(q.pop_front());
            if (wv || rv) begin
                item = wv ? {1'b0, wa, wd, TSW'(m_ts)} : {1'b1, ra, rdd, TSW'(m_ts)};
                if (q.size() < DEPTH) q.push_back(item);
                else lost++;
            end
            if (wv && rv) lost++;
            m_drops = (m_drops + lost > 255) ? 255 : m_drops + lost;
            if (tick) m_ts = (m_ts + 1) % (1 << TSW);
        end
        n++;
        live = 1'b1;
    end

    always @(negedge clk) begin
        if (live) begin
            check("model_valid", 64'(out_valid), 64'(q.size() > 0));
            check("model_level", 64'(level), 64'(q.size()));
            check("model_drops", 64'(drops), 64'(m_drops));
            if (q.size() > 0) begin
                check("model_head", 64'({out_kind, out_addr, out_data, out_time}), 64'(q[0]));
            end
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int low, input bit pop_at_rise);
        ncs     = a[15];
        adr     = a[14:0];
        data_in = d;
        nwr     = 1'b0;
        repeat (low) @(negedge clk);
        nwr       = 1'b1;
        out_ready = pop_at_rise;
        @(negedge clk);
        out_ready = 1'b0;
        ncs       = 1'b1;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
    endtask

    initial begin
        logic [15:0] ea;
        int wr_left, rd_left;
        n_reset = 1'b0; nwr = 1'b1; nrd = 1'b1; ncs = 1'b1; adr = '0; data_in = '0;
        tick = 1'b1; cap_reads = 1'b0; clear = 1'b0; out_ready = 1'b0;
        cycles(3);
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_level", 64'(level), 64'(0));
        check("rst_drops", 64'(drops), 64'(0));
        check("rst_head", 64'({out_kind, out_addr, out_data, out_time}), 64'(0));

        n_reset = 1'b1;
        do_clear();
        cycles(1);
        bus_write(16'h01FF, 8'h31, 4, 1'b0);
        check("wr_valid", 64'(out_valid), 64'(1));
        check("wr_addr", 64'(out_addr), 64'(16'h01FF));
        check("wr_data", 64'(out_data), 64'(8'h31));
        check("wr_kind", 64'(out_kind), 64'(0));
        check("wr_time", 64'(out_time), 64'(5));
        pop_one();
        check("wr_popped", 64'(level), 64'(0));

        bus_write(16'h0123, 8'h55, 1, 1'b0);
        check("short_valid", 64'(out_valid), 64'(0));
        check("short_drops", 64'(drops), 64'(0));
        bus_write(16'h0100, 8'hA5, 2, 1'b0);
        check("minlow_level", 64'(level), 64'(1));
        check("minlow_addr", 64'(out_addr), 64'(16'h0100));
        pop_one();
        bus_write(16'h8100, 8'h11, 3, 1'b0);
        check("ncs_high_level", 64'(level), 64'(0));

        do_clear();
        cycles(1);
        for (int i = 0; i < 17; i++) bus_write(16'h0040 + 16'(i), 8'(i * 7), 2, 1'b0);
        check("full_level", 64'(level), 64'(16));
        check("full_drops", 64'(drops), 64'(1));
        bus_write(16'h0077, 8'hEE, 3, 1'b1);
        check("fullpop_level", 64'(level), 64'(16));
        check("fullpop_drops", 64'(drops), 64'(1));
        for (int i = 0; i < 16; i++) begin
            ea = (i < 15) ? 16'h0041 + 16'(i) : 16'h0077;
            check("drain_addr", 64'(out_addr), 64'(ea));
            pop_one();
        end
        check("drain_level", 64'(level), 64'(0));
        check("drain_valid", 64'(out_valid), 64'(0));

        do_clear();
        cycles(1);
        cap_reads = 1'b1; ncs = 1'b0; adr = 15'h0200; data_in = 8'h9C; nwr = 1'b0; nrd = 1'b0;
        cycles(3);
        nwr = 1'b1; nrd = 1'b1;
        cycles(1);
        ncs = 1'b1;
        check("both_level", 64'(level), 64'(1));
        check("both_kind", 64'(out_kind), 64'(0));
        check("both_drops", 64'(drops), 64'(1));
        do_clear();
        check("clr_level", 64'(level), 64'(0));
        check("clr_drops", 64'(drops), 64'(0));
        cycles(1);
        bus_write(16'h0300, 8'h12, 2, 1'b0);
        check("clr_time", 64'(out_time), 64'(3));
        pop_one();

        ncs = 1'b0; adr = 15'h0010; nrd = 1'b0;
        cycles(2);
        cap_reads = 1'b0;
        cycles(1);
        cap_reads = 1'b1;
        cycles(2);
        nrd = 1'b1;
        cycles(1);
        check("abort_level", 64'(level), 64'(0));

        ncs = 1'b0; adr = 15'h0020; nwr = 1'b0;
        cycles(2);
        n_reset = 1'b0;
        cycles(1);
        n_reset = 1'b1;
        cycles(2);
        nwr = 1'b1;
        cycles(1);
        check("rstmid_valid", 64'(out_valid), 64'(0));
        bus_write(16'h0021, 8'h42, 3, 1'b0);
        check("rstmid_next", 64'(level), 64'(1));
        pop_one();

        wr_left = 0;
        rd_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (wr_left > 0) begin
                wr_left--;
                if (wr_left == 0) nwr = 1'b1;
            end else if ($urandom_range(5) == 0) begin
                nwr = 1'b0;
                wr_left = $urandom_range(6, 1);
            end
            if (rd_left > 0) begin
                rd_left--;
                if (rd_left == 0) nrd = 1'b1;
            end else if ($urandom_range(5) == 0) begin
                nrd = 1'b0;
                rd_left = $urandom_range(6, 1);
            end
            if ($urandom_range(49) == 0) cap_reads = ~cap_reads;
            ncs = ($urandom_range(7) == 0);
            if ($urandom_range(1) == 0) adr = 15'($urandom);
            if ($urandom_range(1) == 0) data_in = 8'($urandom);
            tick      = 1'($urandom_range(1));
            out_ready = ((c % 1000) < 400) ? ($urandom_range(7) == 0) : ($urandom_range(3) != 0);
            clear     = ($urandom_range(299) == 0);
            n_reset   = !($urandom_range(699) == 0);
            cycles(1);
        end
        nwr = 1'b1; nrd = 1'b1; clear = 1'b0; n_reset = 1'b1; out_ready = 1'b1;
        cycles(30);
        check("final_level", 64'(level), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
